stone_drawer: RTL

STONE_DRAWER -- requirements
Module: stone_drawer

---
 rtl/stone_drawer_pkg.sv | 56 +++++
 rtl/stone_drawer_sprite_scan.sv | 50 +++++
 rtl/stone_drawer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stone_drawer_pkg.sv
// Shared definitions for the stone sprite drawer and the rope controller:
// stone-word layout, stone types, screen limits, sprite size, default colours.
package stone_drawer_pkg;

    // Stone word field positions
    localparam int unsigned WordXMsb    = 31;
    localparam int unsigned WordXLsb    = 23;
    localparam int unsigned WordYMsb    = 18;
    localparam int unsigned WordYLsb    = 11;
    localparam int unsigned WordTypeMsb = 3;
    localparam int unsigned WordTypeLsb = 2;
    localparam int unsigned WordVisBit  = 1;
    localparam int unsigned WordMovBit  = 0;

    typedef enum logic [1:0] {
        TypeStone   = 2'd0,
        TypeGold    = 2'd1,
        TypeDiamond = 2'd2
    } stone_type_e;

    // Screen and sprite geometry
    localparam int unsigned ScreenW    = 320;
    localparam int unsigned ScreenH    = 240;
    localparam int unsigned SpriteSize = 16;
    localparam int unsigned SpriteW    = 4;

    // Default 9-bit RGB colours
    localparam logic [8:0] ColStoneDef   = 9'o444;
    localparam logic [8:0] ColGoldDef    = 9'o770;
    localparam logic [8:0] ColDiamondDef = 9'o077;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAddr  = 3'd1,
        StWait  = 3'd2,
        StLatch = 3'd3,
        StPlot  = 3'd4,
        StNext  = 3'd5,
        StDone  = 3'd6
    } draw_state_e;

    // Type code 3 is treated as diamond along with 2
    function automatic logic [8:0] stone_colour(input logic [1:0] kind,
                                                input logic [8:0] col_stone,
                                                input logic [8:0] col_gold,
                                                input logic [8:0] col_diamond);
        if (kind[1]) begin
            return col_diamond;
        end else if (kind == TypeGold) begin
            return col_gold;
        end else begin
            return col_stone;
        end
    endfunction

endpackage

// File: rtl/stone_drawer_sprite_scan.sv
// 16x16 raster counter for one sprite: column runs fastest, row advances on
// column wrap. last_o flags the final pixel of the sprite.
module stone_drawer_sprite_scan
    import stone_drawer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               step_i,
    output logic [SpriteW-1:0] row_o,
    output logic [SpriteW-1:0] col_o,
    output logic               last_o
);

    localparam logic [SpriteW-1:0] LastPos = SpriteW'(SpriteSize - 1);

    logic [SpriteW-1:0] row_q, row_d;
    logic [SpriteW-1:0] col_q, col_d;

    // Next raster position: clear wins over step
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (step_i) begin
            col_d = col_q + 1'b1;
            if (col_q == LastPos) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // Position registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (row_q == LastPos) && (col_q == LastPos);

endmodule

// File: rtl/stone_drawer.sv
// Stone drawer: walks the stone table in RAM and plots each visible stone as
// a 16x16 sprite, one pixel per clock, clipping pixels that fall off-screen.
module stone_drawer
    import stone_drawer_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter logic [8:0]  COL_STONE   = ColStoneDef,
    parameter logic [8:0]  COL_GOLD    = ColGoldDef,
    parameter logic [8:0]  COL_DIAMOND = ColDiamondDef
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] ram_q,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [8:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WaitW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((RAM_LATENCY == 0) ? 0 : RAM_LATENCY - 1);

    draw_state_e       state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [31:0]       word_q, word_d;

    logic               scan_clear, scan_step, scan_last;
    logic [SpriteW-1:0] scan_row, scan_col;
    logic [9:0]         pix_x, pix_y;
    logic               unused_word;

    stone_drawer_sprite_scan u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear_i (scan_clear),
        .step_i  (scan_step),
        .row_o   (scan_row),
        .col_o   (scan_col),
        .last_o  (scan_last)
    );

    // State and datapath registers; reset has priority over start
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wait_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            word_q  <= word_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        word_d     = word_q;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = (quantity == 4'd0) ? StDone : StAddr;
                end
            end
            StAddr: begin
                wait_d  = '0;
                state_d = (RAM_LATENCY == 0) ? StLatch : StWait;
            end
            StWait: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == WaitLast) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                word_d     = ram_q;
                scan_clear = 1'b1;
                state_d    = ram_q[WordVisBit] ? StPlot : StNext;
            end
            StPlot: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                // 5-bit index so quantity 15 terminates instead of wrapping
                idx_d   = idx_q + 5'd1;
                state_d = (idx_q + 5'd1 == {1'b0, quantity}) ? StDone : StAddr;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; pixel maths at 10 bits for clipping
    always_comb begin
        pix_x = {1'b0, word_q[WordXMsb:WordXLsb]} + {6'd0, scan_col};
        pix_y = {2'b0, word_q[WordYMsb:WordYLsb]} + {6'd0, scan_row};

        busy            = (state_q != StIdle);
        draw_stone_flag = busy;
        draw_index      = busy ? idx_q[3:0] : 4'd0;
        done            = (state_q == StDone);
        x               = '0;
        y               = '0;
        colour          = '0;
        plot            = 1'b0;
        if (state_q == StPlot) begin
            x      = pix_x[8:0];
            y      = pix_y[7:0];
            colour = stone_colour(word_q[WordTypeMsb:WordTypeLsb], COL_STONE, COL_GOLD,
                                  COL_DIAMOND);
            plot   = (pix_x < 10'(ScreenW)) && (pix_y < 10'(ScreenH));
        end
    end

    // Padding bits, visibility (decided at latch time) and moving flag are not needed later
    assign unused_word = ^{word_q[22:19], word_q[10:4], word_q[WordVisBit], word_q[WordMovBit]};

endmodule
